// File: rtl/ccg_eval_sequencer.sv
// Drives one combinational netlist with LFSR or host vectors, captures each result after a
// settle interval, streams it out over a valid/ready port and folds it into a 16-bit MISR.
module ccg_eval_sequencer #(
  parameter int IN_W   = 21,
  parameter int OUT_W  = 10,
  parameter int SETTLE = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             mode_i,
  input  logic [CNT_W-1:0] vec_count_i,
  input  logic [IN_W-1:0]  seed_i,
  input  logic             vec_valid_i,
  output logic             vec_ready_o,
  input  logic [IN_W-1:0]  vec_data_i,
  output logic [IN_W-1:0]  dut_in_o,
  input  logic [OUT_W-1:0] dut_out_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [OUT_W-1:0] res_data_o,
  output logic [15:0]      signature_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int TAP2 = (IN_W >= 3) ? IN_W - 3 : 0;
  localparam int SW   = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_APPLY, S_CAPTURE, S_EMIT, S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] total_q, total_d;
  logic [IN_W-1:0]  lfsr_q, lfsr_d;
  logic [IN_W-1:0]  dut_in_q, dut_in_d;
  logic [OUT_W-1:0] res_q, res_d;
  logic [15:0]      sig_q, sig_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic             mode_q, mode_d;
  logic [15:0]      out_ext;
  logic             misr_fb;

  assign out_ext = 16'(dut_out_i);
  assign misr_fb = sig_q[15] ^ sig_q[14] ^ sig_q[12] ^ sig_q[3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      total_q  <= '0;
      lfsr_q   <= IN_W'(1);
      dut_in_q <= '0;
      res_q    <= '0;
      sig_q    <= '0;
      settle_q <= '0;
      mode_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      total_q  <= total_d;
      lfsr_q   <= lfsr_d;
      dut_in_q <= dut_in_d;
      res_q    <= res_d;
      sig_q    <= sig_d;
      settle_q <= settle_d;
      mode_q   <= mode_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    total_d     = total_q;
    lfsr_d      = lfsr_q;
    dut_in_d    = dut_in_q;
    res_d       = res_q;
    sig_d       = sig_q;
    settle_d    = settle_q;
    mode_d      = mode_q;
    vec_ready_o = 1'b0;
    res_valid_o = 1'b0;
    done_o      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          total_d = vec_count_i;
          mode_d  = mode_i;
          lfsr_d  = (seed_i == '0) ? IN_W'(1) : seed_i;
          sig_d   = '0;
          count_d = '0;
          state_d = (vec_count_i == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        settle_d = '0;
        if (!mode_q) begin
          dut_in_d = lfsr_q;
          lfsr_d   = {lfsr_q[IN_W-2:0], lfsr_q[IN_W-1] ^ lfsr_q[TAP2]};
          state_d  = S_APPLY;
        end else begin
          vec_ready_o = 1'b1;
          if (vec_valid_i) begin
            dut_in_d = vec_data_i;
            state_d  = S_APPLY;
          end
        end
      end
      S_APPLY: begin
        if (settle_q == SW'(SETTLE - 1)) state_d = S_CAPTURE;
        else                             settle_d = settle_q + 1'b1;
      end
      S_CAPTURE: begin
        res_d   = dut_out_i;
        sig_d   = {sig_q[14:0], misr_fb} ^ out_ext;
        count_d = count_q + 1'b1;
        state_d = S_EMIT;
      end
      S_EMIT: begin
        res_valid_o = 1'b1;
        // Equality only, so the all-ones vector count runs to completion.
        if (res_ready_i) state_d = (count_q == total_q) ? S_DONE : S_LOAD;
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (abort_i) begin
      state_d  = S_IDLE;
      dut_in_d = dut_in_q;
      res_d    = res_q;
      sig_d    = sig_q;
    end
  end

  assign dut_in_o    = dut_in_q;
  assign res_data_o  = res_q;
  assign signature_o = sig_q;
  assign busy_o      = (state_q != S_IDLE);

endmodule
